// File: rtl/immgen_pipe.sv
// immgen_pipe: RISC-V immediate decoder followed by a 2-entry (main + skid)
// output buffer. The immediate is decoded when an entry is accepted, so each
// buffered entry holds only {imm, sel, err}. Slot 0 is the main entry that
// drives out_*, and slot 1 is the skid entry. in_ready is registered and is
// high exactly when the skid slot is empty.
// XLEN must be 32 or 64.
module immgen_pipe #(
  parameter int XLEN = 32,
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_sel,
  output logic            out_err,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [2:0] SEL_I     = 3'd0;
  localparam logic [2:0] SEL_S     = 3'd1;
  localparam logic [2:0] SEL_B     = 3'd2;
  localparam logic [2:0] SEL_U     = 3'd3;
  localparam logic [2:0] SEL_J     = 3'd4;
  localparam logic [2:0] SEL_Z     = 3'd5;
  localparam logic [2:0] SEL_SHAMT = 3'd6;

  // Decoded form of the entry currently offered on the input side.
  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  // The opcode field never contributes to any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // Buffer slots: index 0 = main (drives outputs), index 1 = skid.
  logic            slot_valid_reg [2];
  logic            slot_valid_next[2];
  logic [XLEN-1:0] slot_imm_reg   [2];
  logic [XLEN-1:0] slot_imm_next  [2];
  logic [2:0]      slot_sel_reg   [2];
  logic [2:0]      slot_sel_next  [2];
  logic            slot_err_reg   [2];
  logic            slot_err_next  [2];

  logic            in_ready_reg;
  logic            in_ready_next;
  logic [ERRW-1:0] err_cnt_reg;
  logic [ERRW-1:0] err_cnt_next;

  logic push;
  logic pop;

  // Handshakes. A flush cycle never accepts; a transfer is simply
  // out_valid && out_ready at the edge.
  assign push = in_valid && in_ready_reg && !flush;
  assign pop  = slot_valid_reg[0] && out_ready;

  // Immediate decode: sign-extended formats replicate instr[31] up to XLEN;
  // Z and SHAMT are zero-extended. Illegal entries carry a zero immediate.
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (in_sel)
      SEL_I: dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      SEL_S: dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SEL_B: dec_imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      SEL_U: dec_imm = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
      SEL_J: dec_imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      SEL_Z: dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
      SEL_SHAMT: begin
        if (XLEN == 64) begin
          dec_imm = {{(XLEN-6){1'b0}}, in_instr[25:20]};
        end else if (in_instr[25]) begin
          // A 6-bit shift amount has no meaning on a 32-bit datapath.
          dec_err = 1'b1;
        end else begin
          dec_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        end
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Buffer next-state: flush empties everything; a transfer refills main
  // from skid (or straight from the input); otherwise a new entry fills main
  // if empty, else skid. Empty slots are kept zeroed.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot_valid_next[i] = slot_valid_reg[i];
      slot_imm_next[i]   = slot_imm_reg[i];
      slot_sel_next[i]   = slot_sel_reg[i];
      slot_err_next[i]   = slot_err_reg[i];
    end

    if (flush) begin
      for (int i = 0; i < 2; i++) begin
        slot_valid_next[i] = 1'b0;
        slot_imm_next[i]   = '0;
        slot_sel_next[i]   = '0;
        slot_err_next[i]   = 1'b0;
      end
    end else if (pop) begin
      if (slot_valid_reg[1]) begin
        slot_valid_next[0] = 1'b1;
        slot_imm_next[0]   = slot_imm_reg[1];
        slot_sel_next[0]   = slot_sel_reg[1];
        slot_err_next[0]   = slot_err_reg[1];
      end else if (push) begin
        slot_valid_next[0] = 1'b1;
        slot_imm_next[0]   = dec_imm;
        slot_sel_next[0]   = in_sel;
        slot_err_next[0]   = dec_err;
      end else begin
        slot_valid_next[0] = 1'b0;
        slot_imm_next[0]   = '0;
        slot_sel_next[0]   = '0;
        slot_err_next[0]   = 1'b0;
      end
      // Skid is never occupied while push is possible, so after a transfer
      // it is always empty.
      slot_valid_next[1] = 1'b0;
      slot_imm_next[1]   = '0;
      slot_sel_next[1]   = '0;
      slot_err_next[1]   = 1'b0;
    end else if (push) begin
      if (!slot_valid_reg[0]) begin
        slot_valid_next[0] = 1'b1;
        slot_imm_next[0]   = dec_imm;
        slot_sel_next[0]   = in_sel;
        slot_err_next[0]   = dec_err;
      end else begin
        slot_valid_next[1] = 1'b1;
        slot_imm_next[1]   = dec_imm;
        slot_sel_next[1]   = in_sel;
        slot_err_next[1]   = dec_err;
      end
    end
  end

  // in_ready mirrors the next skid occupancy so it can be registered.
  always_comb begin
    in_ready_next = !slot_valid_next[1];
  end

  // Error counter steps on each delivered illegal entry and sticks at all-ones.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (pop && slot_err_reg[0] && (err_cnt_reg != {ERRW{1'b1}})) begin
      err_cnt_next = err_cnt_reg + 1'b1;
    end
  end

  // One register bank per buffer slot.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      // Slot storage, cleared asynchronously by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid_reg[gi] <= 1'b0;
          slot_imm_reg[gi]   <= '0;
          slot_sel_reg[gi]   <= '0;
          slot_err_reg[gi]   <= 1'b0;
        end else begin
          slot_valid_reg[gi] <= slot_valid_next[gi];
          slot_imm_reg[gi]   <= slot_imm_next[gi];
          slot_sel_reg[gi]   <= slot_sel_next[gi];
          slot_err_reg[gi]   <= slot_err_next[gi];
        end
      end
    end
  endgenerate

  // in_ready and the error counter; in_ready stays low through reset and
  // rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_reg <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      in_ready_reg <= in_ready_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = slot_valid_reg[0];
  assign out_imm   = slot_valid_reg[0] ? slot_imm_reg[0] : '0;
  assign out_sel   = slot_valid_reg[0] ? slot_sel_reg[0] : '0;
  assign out_err   = slot_valid_reg[0] && slot_err_reg[0];
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: three instances share one stimulus stream:
//   d32 (XLEN=32, ERRW=16), d64 (XLEN=64, ERRW=16), de2 (XLEN=32, ERRW=2).
// A table of directed decode vectors runs first, followed by hand-written
// sequences for backpressure, flush, counter saturation and async reset.
module tb_immgen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_sel;
  logic        out_ready;

  logic        r32, r64, re2;
  logic        v32, v64, ve2;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [31:0] imme2;
  logic [2:0]  sel32, sel64, sele2;
  logic        err32, err64, erre2;
  logic [15:0] cnt32, cnt64;
  logic [1:0]  cnte2;

  int checks = 0;
  int errors = 0;

  immgen_pipe #(.XLEN(32), .ERRW(16)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_sel(in_sel), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_sel(sel32), .out_err(err32), .err_cnt(cnt32));

  immgen_pipe #(.XLEN(64), .ERRW(16)) d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_sel(in_sel), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_sel(sel64), .out_err(err64), .err_cnt(cnt64));

  immgen_pipe #(.XLEN(32), .ERRW(2)) de2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(re2),
    .in_instr(in_instr), .in_sel(in_sel), .out_valid(ve2), .out_ready(out_ready),
    .out_imm(imme2), .out_sel(sele2), .out_err(erre2), .err_cnt(cnte2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] exp32;
    logic        experr32;
    logic [63:0] exp64;
    logic        experr64;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s);
    in_valid = v;
    in_instr = ins;
    in_sel   = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", {63'b0, v32}, 64'd0);
    check("reset in_ready", {63'b0, r32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post-reset in_ready", {63'b0, r32}, 64'd1);
  endtask

  initial begin
    rst_n     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0);

    //            instr          sel   exp32         e32   exp64                   e64
    vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // I  -1
    vecs[1]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // B  -4
    vecs[2]  = '{32'h123450B7, 3'd3, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0}; // U
    vecs[3]  = '{32'h0010006F, 3'd4, 32'h00000800, 1'b0, 64'h0000000000000800, 1'b0}; // J  2048
    vecs[4]  = '{32'h800000B7, 3'd3, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0}; // U  neg
    vecs[5]  = '{32'h03F0D093, 3'd6, 32'h00000000, 1'b1, 64'h000000000000003F, 1'b0}; // SHAMT 63
    vecs[6]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // S  -4
    vecs[7]  = '{32'h800F9073, 3'd5, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0}; // Z  zext
    vecs[8]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1}; // reserved
    vecs[9]  = '{32'h01F0D093, 3'd6, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0}; // SHAMT 31
    vecs[10] = '{32'h7FF00013, 3'd0, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0}; // I  +2047
    vecs[11] = '{32'h800000EF, 3'd4, 32'hFFF00000, 1'b0, 64'hFFFFFFFFFFF00000, 1'b0}; // J  min

    do_reset();

    // Back-to-back stream with out_ready high: each entry shows one cycle
    // after it is accepted.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].sel);
      step();
      check($sformatf("vec%0d valid", i), {63'b0, v32}, 64'd1);
      check($sformatf("vec%0d imm32", i), {32'b0, imm32}, {32'b0, vecs[i].exp32});
      check($sformatf("vec%0d err32", i), {63'b0, err32}, {63'b0, vecs[i].experr32});
      check($sformatf("vec%0d sel", i), {61'b0, sel32}, {61'b0, vecs[i].sel});
      check($sformatf("vec%0d imm64", i), imm64, vecs[i].exp64);
      check($sformatf("vec%0d err64", i), {63'b0, err64}, {63'b0, vecs[i].experr64});
      check($sformatf("vec%0d in_ready", i), {63'b0, r32}, 64'd1);
    end
    drive(1'b0, 32'h0, 3'd0);
    step();
    check("stream drained valid", {63'b0, v32}, 64'd0);
    check("stream drained imm", {32'b0, imm32}, 64'd0);
    check("stream err_cnt32", {48'b0, cnt32}, 64'd2);
    check("stream err_cnt64", {48'b0, cnt64}, 64'd1);

    // Backpressure: three offers with out_ready low, only two fit.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100013, 3'd0);  // imm 1
    step();
    check("bp e1 shown", {32'b0, imm32}, 64'd1);
    check("bp ready after e1", {63'b0, r32}, 64'd1);
    drive(1'b1, 32'h00200013, 3'd0);  // imm 2
    step();
    check("bp ready after e2", {63'b0, r32}, 64'd0);
    check("bp e1 stable", {32'b0, imm32}, 64'd1);
    drive(1'b1, 32'h00300013, 3'd0);  // imm 3, held offered
    step();
    check("bp ready held", {63'b0, r32}, 64'd0);
    check("bp e1 still", {32'b0, imm32}, 64'd1);
    step();
    check("bp e1 still 2", {32'b0, imm32}, 64'd1);
    out_ready = 1'b1;
    step();
    check("bp deliver e2", {32'b0, imm32}, 64'd2);
    check("bp ready back", {63'b0, r32}, 64'd1);
    step();
    drive(1'b0, 32'h0, 3'd0);
    check("bp deliver e3", {32'b0, imm32}, 64'd3);
    step();
    check("bp empty", {63'b0, v32}, 64'd0);

    // Flush with two entries buffered and a new entry offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00013, 3'd0);
    step();
    drive(1'b1, 32'h00B00013, 3'd0);
    step();
    check("fl full ready", {63'b0, r32}, 64'd0);
    drive(1'b1, 32'h00C00013, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0);
    check("fl out_valid", {63'b0, v32}, 64'd0);
    check("fl in_ready", {63'b0, r32}, 64'd1);
    check("fl imm zero", {32'b0, imm32}, 64'd0);
    out_ready = 1'b1;
    step();
    check("fl nothing appears", {63'b0, v32}, 64'd0);
    step();
    check("fl nothing appears 2", {63'b0, v64}, 64'd0);

    // Saturating error counter on the ERRW=2 instance.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h0, 3'd7);
      step();
      check($sformatf("sat cnt e2 step%0d", k), {62'b0, cnte2}, (k > 3) ? 64'd3 : 64'(k));
      check($sformatf("sat cnt 32 step%0d", k), {48'b0, cnt32}, 64'(k));
    end
    drive(1'b0, 32'h0, 3'd0);
    step();
    check("sat cnt e2 final", {62'b0, cnte2}, 64'd3);
    check("sat cnt 32 final", {48'b0, cnt32}, 64'd5);

    // Reset mid-stream with an entry buffered: clears without a clock edge.
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 3'd7);
    step();
    drive(1'b0, 32'h0, 3'd0);
    check("ar valid before", {63'b0, ve2}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar err_cnt", {62'b0, cnte2}, 64'd0);
    check("ar out_valid", {63'b0, ve2}, 64'd0);
    check("ar out_err", {63'b0, erre2}, 64'd0);
    check("ar in_ready", {63'b0, re2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar ready after", {63'b0, re2}, 64'd1);
    check("ar entry lost", {63'b0, ve2}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
